mux_n_1_arb_v: RTL and testbench
================================

Name: mux_n_1_arb_v

Overview:
Parametrised N-channel, WIDTH-bit multiplexer that adds a registered output stage with valid/ready handshakes. It has two selection modes: fixed select by i_sel_code, or round-robin arbitration among the valid channels. It is the sequential successor to the combinational 4:1 8-bit MUX in the datapath components. It sits between multiple producer channels and a single downstream consumer.

Parameters:
N_CH, 4, number of input channels (2..16); select width SEL_W = clog2(N_CH), derived internally.
WIDTH, 8, data width per channel.

Ports:
i_clk  input  1  rising-edge clock
i_rst_n  input  1  reset, asynchronous, active-low
i_en  input  1  grant enable; 0 = accept nothing (output stage still drains)
i_mode  input  1  0 = fixed select, 1 = round-robin
i_sel_code  input  SEL_W  channel index used in fixed mode
i_code  input  N_CH*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH]
i_valid  input  N_CH  per-channel valid
o_ready  output  N_CH  one-hot grant/accept; a transfer on channel k = i_valid[k] & o_ready[k] at the clock edge
o_code  output  WIDTH  registered selected data
o_sel_code  output  SEL_W  index of the channel that produced o_code
o_valid  output  1  o_code holds an untaken word
i_ready  input  1  downstream accepts o_code when o_valid & i_ready

Behaviour:
- Reset values (async on i_rst_n low, held while low):
  - o_valid=0, o_code=0, o_sel_code=0, internal rr_ptr=0.
  - o_ready=0 is forced combinationally while i_rst_n=0.
- Slot free condition: slot_free = !o_valid | i_ready.
- Grant candidate, fixed mode (i_mode=0):
  - Candidate is k = i_sel_code when i_valid[k]=1.
  - i_sel_code >= N_CH gives no grant.
- Grant candidate, round-robin mode (i_mode=1):
  - Candidate is the first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
- Grant rule: o_ready = onehot(candidate) iff i_en & slot_free & candidate exists; otherwise all zero.
  - o_ready is combinational from i_valid, i_en, i_mode, i_sel_code, i_ready and registered state.
  - At most one bit of o_ready is ever set.
- On a grant edge:
  - o_code <= channel data, o_sel_code <= k, o_valid <= 1.
  - In round-robin mode only, rr_ptr <= (k+1) mod N_CH, wrapping from N_CH-1 to 0.
  - Fixed-mode grants leave rr_ptr unchanged.
- On a no-grant edge:
  - If o_valid & i_ready, then o_valid <= 0; o_code and o_sel_code hold their last values (not cleared).
  - Otherwise all registers hold.
- Latency: 1 cycle from accept edge to o_valid=1.
- Throughput: 1 word/cycle while i_ready=1. A simultaneous drain and grant on the same edge replaces the word with no bubble.
- Backpressure: with o_valid=1 and i_ready=0, o_ready=0 and o_code/o_sel_code are stable until taken.
- i_en=0: no new grants, but an existing word still drains normally. Re-enabling resumes from the current rr_ptr.
- i_mode change takes effect on the same cycle's grant evaluation; rr_ptr is retained across mode changes.
- Channel i_valid deasserting without a grant is legal; no data is latched.
- Reset mid-operation: the held word is discarded, o_valid drops immediately (async), and rr_ptr returns to 0.

Test Plan (N_CH=4, WIDTH=8):
1. Reset: i_rst_n=0 with all i_valid=1 -> o_valid=0, o_code=0x00, o_sel_code=0, o_ready=0000; release -> first grant to ch0 in mode 1.
2. Fixed select: i_mode=0, i_sel_code=2, i_valid=0100, ch2=0xA5, i_ready=1 -> o_ready=0100 that cycle; next cycle o_valid=1, o_code=0xA5, o_sel_code=2. Then i_sel_code=1 with i_valid[1]=0 -> o_ready=0000, o_valid drops.
3. Backpressure: o_valid=1 (0xA5), i_ready=0 for 3 cycles with ch2 valid=0x5A -> o_ready=0000, o_code stays 0xA5; i_ready=1 -> o_ready=0100 that cycle, o_code=0x5A the next cycle.
4. Round-robin fairness: i_mode=1, i_valid=1111, data 0x10/0x11/0x12/0x13, i_ready=1 -> o_code sequence 0x10, 0x11, 0x12, 0x13, 0x10 on consecutive cycles (wrap 3->0).
5. Round-robin skip and wrap: rr_ptr=1, i_valid=1001 -> grant ch3 (o_sel_code=3), then ch0, then ch3; never ch1/ch2.
6. Enable and async reset: i_en=0 with o_valid=1, i_ready=1 -> o_valid drops, o_ready=0000. Then i_en=1, stream running, assert i_rst_n low mid-cycle -> o_valid=0 before the next edge, and the next grant after release starts from ch0.

Source files
------------

// File: rtl/mux_n_1_arb_v.sv
// N-channel registered multiplexer with valid/ready handshakes.
// Selects a producer by fixed index or by round-robin search from a rotating pointer.
module mux_n_1_arb_v #(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel_code,
  input  logic [N_CH*WIDTH-1:0] i_code,
  input  logic [N_CH-1:0]       i_valid,
  output logic [N_CH-1:0]       o_ready,
  output logic [WIDTH-1:0]      o_code,
  output logic [SEL_W-1:0]      o_sel_code,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [WIDTH-1:0] code_q, code_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] cand;
  logic             cand_vld;
  logic             slot_free;
  logic             grant;
  int               rr_idx;

  assign slot_free = !valid_q || i_ready;

  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    rr_idx   = 0;
    if (!i_mode) begin
      // Out-of-range select codes simply never match a channel.
      for (int k = 0; k < N_CH; k++) begin
        if (i_sel_code == SEL_W'(k) && i_valid[k]) begin
          cand     = SEL_W'(k);
          cand_vld = 1'b1;
        end
      end
    end else begin
      // Walk farthest-to-nearest so the channel closest to the pointer wins last.
      for (int i = N_CH - 1; i >= 0; i--) begin
        rr_idx = int'(rr_q) + i;
        if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
        if (i_valid[rr_idx]) begin
          cand     = SEL_W'(rr_idx);
          cand_vld = 1'b1;
        end
      end
    end
  end

  assign grant   = i_rst_n && i_en && slot_free && cand_vld;
  assign o_ready = grant ? (N_CH'(1) << cand) : '0;

  always_comb begin
    code_d  = code_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    if (grant) begin
      code_d  = i_code[int'(cand)*WIDTH +: WIDTH];
      sel_d   = cand;
      valid_d = 1'b1;
      if (i_mode) rr_d = (cand == SEL_W'(N_CH - 1)) ? '0 : cand + 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      code_q  <= code_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  assign o_code     = code_q;
  assign o_sel_code = sel_q;
  assign o_valid    = valid_q;

endmodule

// File: tb/tb_mux_n_1_arb_v.sv
// Self-checking bench for mux_n_1_arb_v: directed scenarios then randomized traffic
// compared against a transaction-level reference model.
module tb_mux_n_1_arb_v;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N*W-1:0] code;
  logic [N-1:0]  valid;
  logic [N-1:0]  o_ready;
  logic [W-1:0]  o_code;
  logic [SW-1:0] o_sel;
  logic          o_valid;
  logic          ready;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit     m_valid;
  int     m_code;
  int     m_sel;
  int     m_ptr;

  always #5 clk = ~clk;

  mux_n_1_arb_v #(.N_CH(N), .WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_sel_code (sel),
    .i_code     (code),
    .i_valid    (valid),
    .o_ready    (o_ready),
    .o_code     (o_code),
    .o_sel_code (o_sel),
    .o_valid    (o_valid),
    .i_ready    (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_cand();
    if (!mode) return valid[sel] ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_code  = 0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic set_data(input int d0, input int d1, input int d2, input int d3);
    code = {d3[7:0], d2[7:0], d1[7:0], d0[7:0]};
  endtask

  // Called just after a falling edge with inputs settled; returns after the next falling edge.
  task automatic cycle();
    logic [N-1:0] er;
    int k;
    #1;
    k  = model_cand();
    er = '0;
    if (en && (!m_valid || ready) && k >= 0) er[k] = 1'b1;
    chk("o_ready", 32'(o_ready), 32'(er));
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_code", 32'(o_code), 32'(m_code[7:0]));
    chk("o_sel_code", 32'(o_sel), 32'(m_sel));
    @(posedge clk);
    if (er != '0) begin
      m_code  = int'(code[k*W +: W]);
      m_sel   = k;
      m_valid = 1;
      if (mode) m_ptr = (k + 1) % N;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b1;
    sel   = '0;
    valid = 4'b1111;
    ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    model_reset();

    // reset held with every channel requesting
    repeat (2) @(negedge clk);
    #1;
    chk("reset_o_valid", 32'(o_valid), 32'd0);
    chk("reset_o_code", 32'(o_code), 32'h00);
    chk("reset_o_sel", 32'(o_sel), 32'd0);
    chk("reset_o_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin fairness straight out of reset: 10,11,12,13,10
    #1;
    chk("rr_first_grant", 32'(o_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq_code", 32'(o_code), 32'h10 + 32'(i % 4));
    end

    // fixed select of channel 2
    mode = 1'b0; sel = 2'd2; valid = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    #1;
    chk("fixed_ready", 32'(o_ready), 32'b0100);
    cycle();
    chk("fixed_code", 32'(o_code), 32'hA5);
    chk("fixed_sel", 32'(o_sel), 32'd2);
    sel = 2'd1;
    cycle();
    chk("fixed_nogrant_drop", 32'(o_valid), 32'd0);
    chk("fixed_hold_code", 32'(o_code), 32'hA5);

    // backpressure: hold 0xA5 while channel 2 offers 0x5A
    sel = 2'd2;
    cycle();
    ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h5A, 8'h00);
    repeat (3) begin
      cycle();
      chk("bp_code_stable", 32'(o_code), 32'hA5);
    end
    ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(o_ready), 32'b0100);
    cycle();
    chk("bp_new_code", 32'(o_code), 32'h5A);

    // round-robin skip and wrap from pointer 1 with channels 0 and 3 requesting
    mode = 1'b1; valid = 4'b1001;
    set_data(8'h20, 8'h21, 8'h22, 8'h23);
    cycle();
    chk("skip_sel_a", 32'(o_sel), 32'd3);
    cycle();
    chk("skip_sel_b", 32'(o_sel), 32'd0);
    cycle();
    chk("skip_sel_c", 32'(o_sel), 32'd3);

    // disable: word drains, nothing new accepted
    en = 1'b0;
    cycle();
    chk("dis_drained", 32'(o_valid), 32'd0);
    cycle();

    // stream running, then reset between edges
    en = 1'b1; valid = 4'b1111;
    cycle();
    cycle();
    chk("pre_reset_valid", 32'(o_valid), 32'd1);
    mid_reset();
    #1;
    chk("post_reset_grant", 32'(o_ready), 32'b0001);
    cycle();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      en    = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      sel   = SW'($urandom_range(N - 1));
      valid = N'($urandom);
      ready = ($urandom_range(3) != 0);
      code  = {$urandom};
      if ($urandom_range(199) == 0) mid_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
